maxnet_mem_loader: RTL and testbench

- Writer side of the Maxnet operand memory; the datapath reads the X vector and W matrix from this block's outputs.
- Accepts a serial stream of 32-bit words over a valid/ready handshake.
- Stores N input activations (X) followed by N*N weights (W, row-major) into internal registers.
- Drives the stored values as flat buses to the datapath and signals when a complete image has been loaded.

---
 rtl/maxnet_pkg.sv | 18 +
 rtl/loader_word_reg.sv | 36 +++
 rtl/maxnet_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_maxnet_mem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared constants and loader state encoding for the Maxnet operand memory
//
// Purpose : word width, neuron count, W matrix size and loader FSM state type.
// Ports   : none (package).
package maxnet_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int W_CNT  = N * N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_X = 2'd1,
    LOAD_W = 2'd2,
    DONE   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/loader_word_reg.sv
// rtl/loader_word_reg.sv - one operand word register with load enable
//
// Purpose : holds one X or W word; captures d when en is high.
// Ports   : clk, rst (async, active-high), en (load enable),
//           d (word to capture), q (stored word).
module loader_word_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/maxnet_mem_loader.sv
// rtl/maxnet_mem_loader.sv - writer side of the Maxnet operand memory (X vector then W matrix)
//
// Purpose : accepts a valid/ready word stream, stores N X words followed by
//           N*N W words (row-major) and presents them as flat buses.
// Ports   : clk, rst (async, active-high), start (reload pulse),
//           lock (datapath busy, stalls writes), in_valid/in_data/in_ready
//           (word stream), x_out/w_out (stored operands), loaded (image
//           complete), load_done (pulse on last W word), sign_err (sticky
//           negative-activation flag).
// Options : MAXNET_LOADER_SIGN_CHK_EN enables the negative-activation check;
//           without it sign_err is tied low.
module maxnet_mem_loader
  import maxnet_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      lock,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [N*DATA_W-1:0]       x_out,
  output logic [W_CNT*DATA_W-1:0]   w_out,
  output logic                      loaded,
  output logic                      load_done,
  output logic                      sign_err
);

  localparam int CNT_W = $clog2(W_CNT);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_CNT - 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_done_q, load_done_d;
  logic             xfer;
  logic             start_acc;
  logic [N-1:0]     x_en;
  logic [W_CNT-1:0] w_en;

  assign in_ready  = ((state_q == LOAD_X) || (state_q == LOAD_W)) && !lock;
  assign xfer      = in_valid && in_ready;
  // start only counts when no load is in progress
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD_X;
          cnt_d   = '0;
        end
      end
      LOAD_X: begin
        if (xfer) begin
          if (cnt_q == X_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_W;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_W: begin
        if (xfer) begin
          if (cnt_q == W_LAST) begin
            cnt_d       = '0;
            state_d     = DONE;
            load_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
    end
  end

  assign loaded    = (state_q == DONE);
  assign load_done = load_done_q;

  // one-hot write enables: the counter selects the word slot of the current phase
  always_comb begin
    x_en = '0;
    w_en = '0;
    for (int i = 0; i < N; i++) begin
      x_en[i] = xfer && (state_q == LOAD_X) && (cnt_q == CNT_W'(i));
    end
    for (int j = 0; j < W_CNT; j++) begin
      w_en[j] = xfer && (state_q == LOAD_W) && (cnt_q == CNT_W'(j));
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_x
    loader_word_reg #(.WIDTH(DATA_W)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (x_en[gi]),
      .d   (in_data),
      .q   (x_out[gi*DATA_W +: DATA_W])
    );
  end

  for (genvar gj = 0; gj < W_CNT; gj++) begin : g_w
    loader_word_reg #(.WIDTH(DATA_W)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (w_en[gj]),
      .d   (in_data),
      .q   (w_out[gj*DATA_W +: DATA_W])
    );
  end

`ifdef MAXNET_LOADER_SIGN_CHK_EN
  logic sign_err_q, sign_err_d;

  // only activations are checked; W words may legitimately be negative
  always_comb begin
    sign_err_d = sign_err_q;
    if (start_acc) begin
      sign_err_d = 1'b0;
    end else if (xfer && (state_q == LOAD_X) && in_data[DATA_W-1]) begin
      sign_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_err_q <= 1'b0;
    end else begin
      sign_err_q <= sign_err_d;
    end
  end

  assign sign_err = sign_err_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign sign_err         = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_mem_loader.sv
// tb/tb_maxnet_mem_loader.sv - self-checking bench for maxnet_mem_loader
module tb_maxnet_mem_loader;
  import maxnet_pkg::*;

  localparam int XW = N * DATA_W;
  localparam int WW = W_CNT * DATA_W;
`ifdef MAXNET_LOADER_SIGN_CHK_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              lock;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [XW-1:0]     x_out;
  logic [WW-1:0]     w_out;
  logic              loaded;
  logic              load_done;
  logic              sign_err;

  maxnet_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lock      (lock),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .w_out     (w_out),
    .loaded    (loaded),
    .load_done (load_done),
    .sign_err  (sign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase 0 idle, 1 collecting X, 2 collecting W, 3 image held
  logic [DATA_W-1:0] mx [N];
  logic [DATA_W-1:0] mw [W_CNT];
  int m_phase;
  int m_idx;
  bit m_pulse;
  bit m_sign;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mx[i] = '0;
    for (int i = 0; i < W_CNT; i++) mw[i] = '0;
    m_phase = 0;
    m_idx   = 0;
    m_pulse = 0;
    m_sign  = 0;
  endtask

  function automatic logic [XW-1:0] exp_x();
    logic [XW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = mx[i];
    return r;
  endfunction

  function automatic logic [WW-1:0] exp_w();
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < W_CNT; i++) r[i*DATA_W +: DATA_W] = mw[i];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_x_out"},     WW'(x_out),     WW'(exp_x()));
    check({tag, "_w_out"},     w_out,          exp_w());
    check({tag, "_loaded"},    WW'(loaded),    WW'(m_phase == 3));
    check({tag, "_load_done"}, WW'(load_done), WW'(m_pulse));
    check({tag, "_sign_err"},  WW'(sign_err),  WW'(m_sign));
  endtask

  // one clock: drive after the falling edge, check ready before the rising
  // edge, advance the model on the rising edge, check storage at the next falling edge
  task automatic cycle(input string tag, input bit s, input bit l, input bit v, input logic [DATA_W-1:0] d);
    bit rdy;
    start    = s;
    lock     = l;
    in_valid = v;
    in_data  = d;
    #1;
    rdy = (m_phase == 1 || m_phase == 2) && !l;
    check({tag, "_in_ready"}, WW'(in_ready), WW'(rdy));
    @(posedge clk);
    m_pulse = 0;
    if (m_phase == 0 || m_phase == 3) begin
      if (s) begin
        m_phase = 1;
        m_idx   = 0;
        m_sign  = 0;
      end
    end else if (v && rdy) begin
      if (m_phase == 1) begin
        mx[m_idx] = d;
        if (SIGN_EN && d[DATA_W-1]) m_sign = 1;
        m_idx++;
        if (m_idx == N) begin
          m_idx   = 0;
          m_phase = 2;
        end
      end else begin
        mw[m_idx] = d;
        m_idx++;
        if (m_idx == W_CNT) begin
          m_idx   = 0;
          m_phase = 3;
          m_pulse = 1;
        end
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  logic [DATA_W-1:0] xs [N];
  int sent;
  int k;

  initial begin
    xs[0] = 5; xs[1] = 3; xs[2] = 9; xs[3] = 1;
    rst = 1'b1; start = 1'b0; lock = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");
    check("reset_in_ready", WW'(in_ready), '0);

    // full load with in_valid held high
    cycle("t1_start", 1, 0, 0, '0);
    for (int i = 0; i < N; i++) cycle("t1_x", 0, 0, 1, xs[i]);
    for (int i = 0; i < W_CNT; i++) cycle("t1_w", 0, 0, 1, DATA_W'(i + 1));
    check("t1_x_const", WW'(x_out), WW'({32'd1, 32'd9, 32'd3, 32'd5}));
    check("t1_w15", WW'(w_out[15*DATA_W +: DATA_W]), WW'(32'd16));
    cycle("t1_idle", 0, 0, 0, '0);
    cycle("t1_idle", 0, 0, 1, 32'hdead_beef);

    // backpressure inside LOAD_W
    cycle("t2_start", 1, 0, 0, '0);
    for (int i = 0; i < N; i++) cycle("t2_x", 0, 0, 1, $urandom());
    for (int i = 0; i < 6; i++) cycle("t2_w", 0, 0, 1, $urandom());
    for (int i = 0; i < 3; i++) cycle("t2_lock", 0, 1, 1, $urandom());
    for (int i = 6; i < W_CNT; i++) cycle("t2_w", 0, 0, 1, $urandom());

    // gaps: in_valid 1,0,0,1,...
    cycle("t3_start", 1, 0, 0, '0);
    sent = 0;
    k = 0;
    while (sent < N + W_CNT) begin
      if (k % 3 == 0) begin
        cycle("t3_v", 0, 0, 1, (sent < N) ? xs[sent] : DATA_W'(sent - N + 1));
        sent++;
      end else begin
        cycle("t3_gap", 0, 0, 0, $urandom());
      end
      k++;
    end
    check("t3_x_const", WW'(x_out), WW'({32'd1, 32'd9, 32'd3, 32'd5}));
    check("t3_w15", WW'(w_out[15*DATA_W +: DATA_W]), WW'(32'd16));

    // partial reload: old W words 4..15 survive
    cycle("t4_start", 1, 0, 0, '0);
    for (int i = 0; i < N; i++) cycle("t4_x", 0, 0, 1, 32'd7);
    for (int i = 0; i < 4; i++) cycle("t4_w", 0, 0, 1, 32'haaaa_aaaa);
    cycle("t4_stop", 0, 0, 0, '0);
    check("t4_x_const", WW'(x_out), WW'({32'd7, 32'd7, 32'd7, 32'd7}));
    check("t4_w0", WW'(w_out[0 +: DATA_W]), WW'(32'haaaa_aaaa));
    check("t4_w4", WW'(w_out[4*DATA_W +: DATA_W]), WW'(32'd5));
    check("t4_w15", WW'(w_out[15*DATA_W +: DATA_W]), WW'(32'd16));
    check("t4_loaded", WW'(loaded), '0);
    cycle("t4_start_ign", 1, 0, 0, '0);

    // async reset mid LOAD_X, between edges
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle("t5_start", 1, 0, 0, '0);
    cycle("t5_x", 0, 0, 1, 32'h1111_1111);
    cycle("t5_x", 0, 0, 1, 32'h2222_2222);
    start = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t5_x_zero", WW'(x_out), '0);
    check("t5_w_zero", w_out, '0);
    check("t5_in_ready", WW'(in_ready), '0);
    check("t5_loaded", WW'(loaded), '0);
    check("t5_sign", WW'(sign_err), '0);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("t5_after");

    // negative activation, then an all-ones weight
    cycle("t6_start", 1, 0, 0, '0);
    cycle("t6_xneg", 0, 0, 1, 32'h8000_0001);
    check("t6_sign_set", WW'(sign_err), WW'(SIGN_EN));
    for (int i = 1; i < N; i++) cycle("t6_x", 0, 0, 1, DATA_W'(i));
    cycle("t6_wneg", 0, 0, 1, 32'hffff_ffff);
    for (int i = 1; i < W_CNT; i++) cycle("t6_w", 0, 0, 1, DATA_W'(i));
    cycle("t6_done", 0, 0, 0, '0);
    cycle("t6_restart", 1, 0, 0, '0);
    check("t6_sign_clr", WW'(sign_err), '0);
    cycle("t6_x", 0, 0, 1, 32'h0000_0001);
    for (int i = 1; i < N; i++) cycle("t6_x2", 0, 0, 1, DATA_W'(i));
    cycle("t6_wneg2", 0, 0, 1, 32'hffff_ffff);
    check("t6_w_nochk", WW'(sign_err), '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rnd", ($urandom_range(7) == 0), ($urandom_range(3) == 0),
            ($urandom_range(3) != 0), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
